// File: rtl/reg_pipe_elastic.sv
// Elastic valid/ready register chain of DEPTH stages with bubble collapsing and flush-to-preset.
// Define REG_PIPE_OCC_EN to add the registered occupancy output occ.
module reg_pipe_elastic #(
    parameter int                DATA_W     = 20,
    parameter int                DEPTH      = 2,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  v_d;
    logic [DEPTH-1:0]  adv;
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];
    logic              up_full;
    logic              in_xfer;
    logic              out_xfer;

    // A stage can move when any stage downstream is empty or the tail drains.
    always_comb begin
        adv     = '0;
        up_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            up_full = 1'b1;
            for (int j = i + 1; j < DEPTH; j++) begin
                up_full = up_full & v_q[j];
            end
            adv[i] = v_q[i] & (out_ready | ~up_full);
        end
    end

    assign in_ready  = (~v_q[0] | adv[0]) & ~flush;
    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign dout      = d_q[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (in_xfer) begin
            v_d[0] = 1'b1;
            d_d[0] = din;
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                v_d[i] = 1'b1;
                d_d[i] = d_q[i-1];
            end else if (adv[i]) begin
                v_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= PRESET_VAL;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

`ifdef REG_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    always_comb begin
        occ_d = occ_q;
        case ({in_xfer, out_xfer})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule
